// File: rtl/ptmch_trg_log.sv
// rtl/ptmch_trg_log.sv - trigger rising-edge logger with 24-bit timestamps and FWFT event FIFO
module ptmch_trg_log #(
    parameter int P_DEPTH = 16,
    parameter int P_LVL_W = 5
) (
    input  logic               RESET_N,
    input  logic               CLK160M,
    input  logic [4:0]         TRG_PLS,
    input  logic [4:0]         TRG_EN,
    input  logic               EVT_RD,
    input  logic               OVF_CLR,
    output logic               EVT_VALID,
    output logic [31:0]        EVT_DATA,
    output logic [P_LVL_W-1:0] EVT_LVL,
    output logic               OVF
);

    localparam int PTR_W = $clog2(P_DEPTH);

    logic [4:0]         trg_q;
    logic [4:0]         trg_qd;
    logic [4:0]         trg_edge;
    logic [23:0]        ts_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [P_LVL_W-1:0] lvl;
    logic               ovf_q;
    logic [31:0]        mem [P_DEPTH];

    logic wr_req;
    logic is_full;
    logic is_empty;
    logic pop;
    logic push;
    logic ovf_set;

    // The enable is applied at edge time only, so enabling mid-pulse cannot create an event.
    assign trg_edge = trg_q & ~trg_qd & TRG_EN;
    assign wr_req   = |trg_edge;
    assign is_full  = (lvl == P_LVL_W'(P_DEPTH));
    assign is_empty = (lvl == '0);
    assign pop      = EVT_RD & ~is_empty;
    // A pop on a full FIFO frees the slot the incoming entry needs.
    assign push     = wr_req & (~is_full | pop);
    assign ovf_set  = wr_req & is_full & ~pop;

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            trg_q  <= '0;
            trg_qd <= '0;
            ts_cnt <= '0;
        end else begin
            trg_q  <= TRG_PLS;
            trg_qd <= trg_q;
            ts_cnt <= ts_cnt + 24'd1;
        end
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + P_LVL_W'(1);
                2'b01:   lvl <= lvl - P_LVL_W'(1);
                default: lvl <= lvl;
            endcase
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (OVF_CLR) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK160M) begin
        if (push) begin
            mem[wr_ptr] <= {trg_edge, 3'b000, ts_cnt};
        end
    end

    // Gating by occupancy keeps the output at zero after reset without resetting the array.
    assign EVT_VALID = ~is_empty;
    assign EVT_DATA  = is_empty ? 32'h0 : mem[rd_ptr];
    assign EVT_LVL   = lvl;
    assign OVF       = ovf_q;

endmodule
